// File: rtl/sli_cam_handshake_if.sv
// Handshake bundle between the structured-light pixel stage, the camera and
// the capture sequencer. The master side is the pixel stage / camera environment.
interface sli_cam_handshake_if;
  logic       mode;
  logic       start;
  logic       in_vsync;
  logic       trig;
  logic       f_frm;
  logic       cam_strobe;
  logic       rdy;
  logic       busy;
  logic [4:0] pat_idx;
  logic       seq_done;
  logic       err;
  logic [7:0] err_cnt;

  modport master (
    output mode, start, in_vsync, trig, f_frm, cam_strobe,
    input  rdy, busy, pat_idx, seq_done, err, err_cnt
  );

  modport slave (
    input  mode, start, in_vsync, trig, f_frm, cam_strobe,
    output rdy, busy, pat_idx, seq_done, err, err_cnt
  );
endinterface

// File: rtl/sli_cam_handshake.sv
// Projector/camera loop closer for structured-light capture: paces the pattern
// generator with rdy, tracks the pattern index and catches trigger/strobe timeouts.
module sli_cam_handshake #(
  parameter int unsigned TIMEOUT_CYC      = 2000000,
  parameter int unsigned TRIG_WAIT_FRAMES = 4,
  parameter int unsigned SETTLE_FRAMES    = 1,
  parameter int unsigned NUM_PAT          = 32
) (
  input logic                clk,
  input logic                rst,
  sli_cam_handshake_if.slave bus
);

  localparam int unsigned CYC_W        = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned TRIG_LAST_I  = (TRIG_WAIT_FRAMES == 0) ? 0 : TRIG_WAIT_FRAMES - 1;
  localparam int unsigned SETTLE_LAST_I = (SETTLE_FRAMES == 0) ? 0 : SETTLE_FRAMES - 1;

  localparam logic [CYC_W-1:0] CYC_LAST    = CYC_W'(TIMEOUT_CYC - 1);
  localparam logic [3:0]       TRIG_LAST   = 4'(TRIG_LAST_I);
  localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE_LAST_I);
  localparam logic [4:0]       PAT_LAST    = 5'(NUM_PAT - 1);
  localparam bit               NO_SETTLE   = (SETTLE_FRAMES == 0);

  typedef enum logic [2:0] {
    IDLE,
    READY,
    RELEASE,
    WAIT_STB,
    EXPOSE,
    SETTLE,
    ADVANCE,
    ERROR
  } state_t;

  state_t           state_q, state_nxt;
  logic [CYC_W-1:0] cyc_cnt_q, cyc_cnt_nxt;
  logic [3:0]       frm_cnt_q, frm_cnt_nxt;
  logic [4:0]       pat_idx_q, pat_idx_nxt;
  logic             err_q, err_nxt;
  logic [7:0]       err_cnt_q, err_cnt_nxt;
  logic             seq_done_q, seq_done_nxt;

  logic strobe_meta, strobe_sync, strobe_d;
  logic trig_d, vsync_d;
  logic vs_rise, tr_rise, st_rise, st_fall;

  // cam_strobe comes from the camera's own clock domain; trig and in_vsync are
  // already pixel-clock synchronous and only need the edge register.
  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (rst) begin
      strobe_meta <= 1'b0;
      strobe_sync <= 1'b0;
      strobe_d    <= 1'b0;
      trig_d      <= 1'b0;
      vsync_d     <= 1'b0;
    end else begin
      strobe_meta <= bus.cam_strobe;
      strobe_sync <= strobe_meta;
      strobe_d    <= strobe_sync;
      trig_d      <= bus.trig;
      vsync_d     <= bus.in_vsync;
    end
  end

  assign vs_rise = bus.in_vsync & ~vsync_d;
  assign tr_rise = bus.trig & ~trig_d;
  assign st_rise = strobe_sync & ~strobe_d;
  assign st_fall = ~strobe_sync & strobe_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cyc_cnt_q  <= '0;
      frm_cnt_q  <= '0;
      pat_idx_q  <= '0;
      err_q      <= 1'b0;
      err_cnt_q  <= '0;
      seq_done_q <= 1'b0;
    end else begin
      state_q    <= state_nxt;
      cyc_cnt_q  <= cyc_cnt_nxt;
      frm_cnt_q  <= frm_cnt_nxt;
      pat_idx_q  <= pat_idx_nxt;
      err_q      <= err_nxt;
      err_cnt_q  <= err_cnt_nxt;
      seq_done_q <= seq_done_nxt;
    end
  end

  // NOTE: every signal driven here gets its hold value first, so no path
  // through the case can leave one unassigned and infer a latch.
  always_comb begin
    state_nxt    = state_q;
    cyc_cnt_nxt  = cyc_cnt_q;
    frm_cnt_nxt  = frm_cnt_q;
    pat_idx_nxt  = pat_idx_q;
    err_nxt      = err_q;
    err_cnt_nxt  = err_cnt_q;
    seq_done_nxt = 1'b0;

    if (!bus.mode) begin
      // Pass-through drops back to IDLE but keeps the index and error history.
      state_nxt = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_nxt   = READY;
            err_nxt     = 1'b0;
            err_cnt_nxt = '0;
            pat_idx_nxt = '0;
          end
        end

        READY: begin
          if (vs_rise) begin
            state_nxt   = RELEASE;
            frm_cnt_nxt = '0;
          end
        end

        RELEASE: begin
          // A trigger on the same edge as VSYNC wins and does not burn a frame.
          if (tr_rise) begin
            state_nxt   = WAIT_STB;
            cyc_cnt_nxt = '0;
            if (bus.f_frm) pat_idx_nxt = '0;
          end else if (vs_rise) begin
            if (frm_cnt_q == TRIG_LAST) state_nxt = ERROR;
            frm_cnt_nxt = frm_cnt_q + 4'd1;
          end
        end

        WAIT_STB: begin
          cyc_cnt_nxt = cyc_cnt_q + CYC_W'(1);
          if (st_rise)                     state_nxt = EXPOSE;
          else if (cyc_cnt_q == CYC_LAST)  state_nxt = ERROR;
        end

        EXPOSE: begin
          // Exposure length belongs to the camera; trig falling early is ignored.
          if (st_fall) begin
            state_nxt   = SETTLE;
            frm_cnt_nxt = '0;
          end
        end

        SETTLE: begin
          if (NO_SETTLE || (vs_rise && frm_cnt_q == SETTLE_LAST)) begin
            state_nxt = ADVANCE;
          end else if (vs_rise) begin
            frm_cnt_nxt = frm_cnt_q + 4'd1;
          end
        end

        ADVANCE: begin
          if (pat_idx_q == PAT_LAST) begin
            seq_done_nxt = 1'b1;
            pat_idx_nxt  = '0;
            state_nxt    = IDLE;
          end else begin
            pat_idx_nxt = pat_idx_q + 5'd1;
            state_nxt   = READY;
          end
        end

        ERROR: begin
          // The failed pattern is skipped: settle, then advance as normal.
          err_nxt     = 1'b1;
          if (err_cnt_q != 8'hFF) err_cnt_nxt = err_cnt_q + 8'd1;
          state_nxt   = SETTLE;
          frm_cnt_nxt = '0;
        end

        default: state_nxt = IDLE;
      endcase
    end
  end

  assign bus.rdy      = (state_q == READY);
  assign bus.busy     = (state_q != IDLE);
  assign bus.pat_idx  = pat_idx_q;
  assign bus.seq_done = seq_done_q;
  assign bus.err      = err_q;
  assign bus.err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_sli_cam_handshake.sv
// Directed bench for sli_cam_handshake: nominal capture loop, both timeouts,
// mode drop, f_frm resync and reset during SETTLE.
module tb_sli_cam_handshake;

  localparam int VPER = 200;

  logic clk;
  logic rst;
  int   vectors     = 0;
  int   miscompares = 0;
  int   rdy_vs_cnt  = 0;
  int   done_cnt    = 0;
  int   vcnt        = 0;
  logic mon_vs_prev = 1'b0;

  sli_cam_handshake_if bus ();

  sli_cam_handshake #(
    .TIMEOUT_CYC     (50),
    .TRIG_WAIT_FRAMES(2),
    .SETTLE_FRAMES   (1),
    .NUM_PAT         (8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Free-running VSYNC: high for 4 of every VPER cycles, updated 1 unit after posedge.
  initial begin
    bus.in_vsync = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      vcnt = (vcnt == VPER - 1) ? 0 : vcnt + 1;
      bus.in_vsync = (vcnt < 4);
    end
  end

  // Counts rdy seen high at VSYNC rising edges, and seq_done pulses.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.in_vsync && !mon_vs_prev && bus.rdy) rdy_vs_cnt++;
      if (bus.seq_done) done_cnt++;
      mon_vs_prev = bus.in_vsync;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_rdy();
    int n = 0;
    while (!bus.rdy && n < 3 * VPER) begin
      tick(1);
      n++;
    end
    check("rdy_wait", bus.rdy, 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.busy && n < 3 * VPER) begin
      tick(1);
      n++;
    end
    check("idle_wait", bus.busy, 0);
  endtask

  task automatic wait_vs_rise();
    logic prev;
    bit   seen = 1'b0;
    int   n    = 0;
    prev = bus.in_vsync;
    while (!seen && n < 2 * VPER) begin
      tick(1);
      n++;
      if (bus.in_vsync && !prev) seen = 1'b1;
      prev = bus.in_vsync;
    end
  endtask

  // One full pattern: release on VSYNC, trigger, 100-cycle exposure.
  task automatic do_pattern(input bit ff, input int exp_idx);
    wait_rdy();
    wait_vs_rise();
    check("rdy_at_vs", bus.rdy, 1);
    tick(1);
    check("rdy_after_vs", bus.rdy, 0);
    bus.f_frm = ff;
    bus.trig  = 1'b1;
    tick(10);
    bus.cam_strobe = 1'b1;
    tick(40);
    bus.trig = 1'b0;
    tick(60);
    bus.cam_strobe = 1'b0;
    bus.f_frm      = 1'b0;
    tick(5);
    check("pat_idx_exposed", bus.pat_idx, exp_idx);
  endtask

  initial begin
    int rdy0, done0;
    rst            = 1'b1;
    bus.mode       = 1'b0;
    bus.start      = 1'b0;
    bus.trig       = 1'b0;
    bus.f_frm      = 1'b0;
    bus.cam_strobe = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(1);
    check("rst_rdy", bus.rdy, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_pat_idx", bus.pat_idx, 0);
    check("rst_seq_done", bus.seq_done, 0);
    check("rst_err", bus.err, 0);
    check("rst_err_cnt", bus.err_cnt, 0);

    // Nominal 8-pattern loop.
    bus.mode = 1'b1;
    tick(1);
    rdy0  = rdy_vs_cnt;
    done0 = done_cnt;
    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
    check("start_to_rdy", bus.rdy, 1);
    check("start_busy", bus.busy, 1);
    for (int p = 0; p < 8; p++) do_pattern(p == 0, p);
    wait_idle();
    tick(2);
    check("nom_seq_done_pulses", done_cnt - done0, 1);
    check("nom_rdy_vs_edges", rdy_vs_cnt - rdy0, 8);
    check("nom_err", bus.err, 0);
    check("nom_pat_idx_wrap", bus.pat_idx, 0);

    // Strobe rise on the exact timeout cycle: the strobe wins.
    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
    wait_vs_rise();
    tick(1);
    bus.trig = 1'b1;
    tick(48);
    bus.cam_strobe = 1'b1;
    tick(4);
    check("race_no_err", bus.err, 0);
    check("race_busy", bus.busy, 1);
    tick(20);
    bus.cam_strobe = 1'b0;
    bus.trig       = 1'b0;
    wait_rdy();
    check("race_pat_idx", bus.pat_idx, 1);
    check("race_err_cnt", bus.err_cnt, 0);

    // Strobe never rises: timeout after 50 WAIT_STB cycles.
    wait_vs_rise();
    tick(1);
    bus.trig = 1'b1;
    tick(51);
    check("stb_to_not_yet", bus.err, 0);
    tick(1);
    check("stb_to_err", bus.err, 1);
    check("stb_to_err_cnt", bus.err_cnt, 1);
    bus.trig = 1'b0;
    wait_rdy();
    check("stb_to_pat_adv", bus.pat_idx, 2);

    // No trigger: error on the second VSYNC rise after release.
    wait_vs_rise();
    tick(1);
    wait_vs_rise();
    tick(1);
    check("trg_to_first_vs", bus.err_cnt, 1);
    check("trg_to_rdy", bus.rdy, 0);
    wait_vs_rise();
    tick(1);
    check("trg_to_entry", bus.err_cnt, 1);
    tick(1);
    check("trg_to_err_cnt", bus.err_cnt, 2);
    wait_rdy();
    check("trg_to_pat_adv", bus.pat_idx, 3);

    // start while busy is ignored.
    do_pattern(1'b0, 3);
    wait_rdy();
    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
    tick(1);
    check("busy_start_pat", bus.pat_idx, 4);
    check("busy_start_errcnt", bus.err_cnt, 2);

    // Resync: f_frm on the trigger forces index 0.
    do_pattern(1'b0, 4);
    do_pattern(1'b1, 0);
    wait_rdy();
    check("resync_adv", bus.pat_idx, 1);

    // mode drop during EXPOSE.
    wait_vs_rise();
    tick(1);
    bus.trig = 1'b1;
    tick(10);
    bus.cam_strobe = 1'b1;
    tick(8);
    bus.mode = 1'b0;
    tick(1);
    check("mode_drop_busy", bus.busy, 0);
    check("mode_drop_rdy", bus.rdy, 0);
    check("mode_drop_pat", bus.pat_idx, 1);
    check("mode_drop_err", bus.err, 1);
    bus.cam_strobe = 1'b0;
    bus.trig       = 1'b0;
    bus.mode       = 1'b1;
    tick(4);
    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
    check("restart_rdy", bus.rdy, 1);
    check("restart_pat", bus.pat_idx, 0);
    check("restart_err", bus.err, 0);
    check("restart_err_cnt", bus.err_cnt, 0);

    // Reset mid-SETTLE, with start held during reset.
    do_pattern(1'b0, 0);
    wait_rdy();
    check("pre_rst_pat", bus.pat_idx, 1);
    wait_vs_rise();
    tick(1);
    bus.trig = 1'b1;
    tick(10);
    bus.cam_strobe = 1'b1;
    tick(20);
    bus.cam_strobe = 1'b0;
    bus.trig       = 1'b0;
    tick(6);
    check("settle_busy", bus.busy, 1);
    rst       = 1'b1;
    bus.start = 1'b1;
    tick(1);
    check("rst_mid_busy", bus.busy, 0);
    check("rst_mid_rdy", bus.rdy, 0);
    check("rst_mid_pat", bus.pat_idx, 0);
    check("rst_mid_err", bus.err, 0);
    check("rst_mid_err_cnt", bus.err_cnt, 0);
    check("rst_mid_seq_done", bus.seq_done, 0);
    tick(1);
    check("rst_start_ignored", bus.busy, 0);
    rst       = 1'b0;
    bus.start = 1'b0;
    tick(2);
    check("post_rst_busy", bus.busy, 0);
    check("post_rst_rdy", bus.rdy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
